// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_pkg
//  Description : Shared default sizing and threshold values for sync_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    localparam int DEF_DATASIZE     = 8;
    localparam int DEF_ADDRSIZE     = 10;
    localparam int DEF_AFULL_LEVEL  = (2 ** DEF_ADDRSIZE) - 4;
    localparam int DEF_AEMPTY_LEVEL = 4;

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/fifomem.sv
`default_nettype none
// ============================================================================
//  Module      : fifomem
//  Description : 2**ADDRSIZE x DATASIZE storage, one write port and one
//                registered read port. Read data holds when no read occurs.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifomem #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wen,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                ren,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata
);

    logic [DATASIZE-1:0] mem [0:(2**ADDRSIZE)-1];

    // Write port: the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; cleared by reset, otherwise holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule : fifomem
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with binary wrap-bit pointers, occupancy
//                count, almost-full/almost-empty flags, flush, and sticky
//                overflow/underflow error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATASIZE     = DEF_DATASIZE,
    parameter int ADDRSIZE     = DEF_ADDRSIZE,
    parameter int AFULL_LEVEL  = DEF_AFULL_LEVEL,
    parameter int AEMPTY_LEVEL = DEF_AEMPTY_LEVEL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    input  logic                flush,
    input  logic                clear_err,
    output logic [DATASIZE-1:0] rdata,
    output logic                rvalid,
    output logic                wfull,
    output logic                rempty,
    output logic                walmost_full,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam logic [ADDRSIZE:0] PTR_ONE    = (ADDRSIZE+1)'(1);
    localparam logic [ADDRSIZE:0] PTR_WRAP   = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [ADDRSIZE:0] AFULL_THR  = (ADDRSIZE+1)'(AFULL_LEVEL);
    localparam logic [ADDRSIZE:0] AEMPTY_THR = (ADDRSIZE+1)'(AEMPTY_LEVEL);

    logic [ADDRSIZE:0] wptr;
    logic [ADDRSIZE:0] rptr;
    logic              wr_ok;
    logic              rd_ok;

    // Flags come from the registered pointers only; full means the pointers
    // match except for the wrap bit.
    assign wfull         = ((wptr ^ rptr) == PTR_WRAP);
    assign rempty        = (wptr == rptr);
    assign count         = wptr - rptr;
    assign walmost_full  = (count >= AFULL_THR);
    assign ralmost_empty = (count <= AEMPTY_THR);

    // Acceptance uses the current-cycle flags, so a read never frees a slot
    // for a write in the same cycle (and vice versa).
    assign wr_ok = winc & ~wfull;
    assign rd_ok = rinc & ~rempty;

    // Pointer, read-valid and sticky error state; flush overrides requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            rvalid    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (flush) begin
                wptr   <= '0;
                rptr   <= '0;
                rvalid <= 1'b0;
            end else begin
                if (wr_ok) begin
                    wptr <= wptr + PTR_ONE;
                end
                if (rd_ok) begin
                    rptr <= rptr + PTR_ONE;
                end
                rvalid <= rd_ok;
            end
            // A new error event in the same cycle beats clear_err.
            overflow  <= (~flush & winc & wfull)  | (overflow  & ~clear_err);
            underflow <= (~flush & rinc & rempty) | (underflow & ~clear_err);
        end
    end

    fifomem #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_fifomem (
        .clk   (clk),
        .rst   (rst),
        .wen   (wr_ok & ~flush),
        .waddr (wptr[ADDRSIZE-1:0]),
        .wdata (wdata),
        .ren   (rd_ok & ~flush),
        .raddr (rptr[ADDRSIZE-1:0]),
        .rdata (rdata)
    );

endmodule : sync_fifo
`default_nettype wire

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDRSIZE, default 10, address width; depth = 2**ADDRSIZE (1024).
REQ-003 SHALL have parameter AFULL_LEVEL, default 2**ADDRSIZE-4, count at or above which walmost_full asserts.
REQ-004 SHALL have parameter AEMPTY_LEVEL, default 4, count at or below which ralmost_empty asserts.
REQ-005 SHALL use one clock and a synchronous active-high reset: clk  input  1  sole clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 winc  input  1  write request.
REQ-008 wdata  input  DATASIZE  write data.
REQ-009 rinc  input  1  read request.
REQ-010 flush  input  1  discard all stored words.
REQ-011 clear_err  input  1  clear sticky error flags.
REQ-012 rdata  output  DATASIZE  registered read data.
REQ-013 rvalid  output  1  rdata holds the word popped in the previous cycle.
REQ-014 wfull  output  1  FIFO full.
REQ-015 rempty  output  1  FIFO empty.
REQ-016 walmost_full  output  1  count >= AFULL_LEVEL.
REQ-017 ralmost_empty  output  1  count <= AEMPTY_LEVEL.
REQ-018 count  output  ADDRSIZE+1  current occupancy, 0..2**ADDRSIZE.
REQ-019 overflow  output  1  sticky: write attempted while full.
REQ-020 underflow  output  1  sticky: read attempted while empty.

Function
REQ-021 Write and read pointers SHALL be ADDRSIZE+1-bit binary; low ADDRSIZE bits address memory, MSB is the wrap bit.
REQ-022 wfull SHALL be 1 when pointers differ only in MSB; rempty SHALL be 1 when pointers are equal; both derived from registered pointers.
REQ-023 count SHALL equal (wptr - rptr) modulo 2**(ADDRSIZE+1) and update in the same cycle as the pointers.
REQ-024 A write SHALL be accepted when winc=1 and wfull=0: wdata stored at wptr, wptr increments.
REQ-025 A read SHALL be accepted when rinc=1 and rempty=0: rptr increments; the head word appears on rdata with rvalid=1 exactly one cycle later.
REQ-026 rvalid SHALL be 0 in any cycle not following an accepted read; rdata SHALL hold its last value while rvalid=0.
REQ-027 Full/empty are evaluated on the current-cycle flags: a write while wfull=1 SHALL be rejected even with a simultaneous accepted read; a read while rempty=1 SHALL be rejected even with a simultaneous write.
REQ-028 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-029 A rejected write SHALL set overflow; a rejected read SHALL set underflow; neither SHALL alter pointers or memory.
REQ-030 clear_err=1 SHALL clear overflow and underflow; a new error event in the same cycle SHALL win (flag stays 1).
REQ-031 flush=1 SHALL set wptr=rptr=0 and rvalid=0 next cycle, overriding winc/rinc that cycle; sticky flags SHALL be unaffected.
REQ-032 Pointers SHALL wrap from 2**(ADDRSIZE+1)-1 to 0 without data loss.

Reset
REQ-033 On rst=1: pointers 0, count 0, rempty 1, wfull 0, ralmost_empty 1, walmost_full 0, rvalid 0, rdata 0, overflow 0, underflow 0.
REQ-034 rst SHALL override flush, clear_err, winc and rinc; memory contents need not be reset.
REQ-035 Reset asserted mid-operation SHALL discard all stored data; after release the FIFO behaves as empty.

Structure
REQ-036 Default DATASIZE, ADDRSIZE, AFULL_LEVEL, AEMPTY_LEVEL SHALL live in the shared definitions package.
REQ-037 Storage SHALL be a sub-module fifomem: 2**ADDRSIZE x DATASIZE, one write port, one registered read port.

Verification
REQ-038 After reset, 1024 writes of 0..255 repeating -> wfull=1 on cycle after 1024th write, count=1024, walmost_full from count 1020.
REQ-039 Write to full FIFO -> overflow=1, count stays 1024; clear_err -> overflow=0.
REQ-040 Read from empty FIFO -> underflow=1, rvalid=0, count=0.
REQ-041 Write 1500 words with one concurrent read per write after 600 -> data out in order, crosses pointer wrap, no loss.
REQ-042 Count=10, winc+rinc+flush same cycle -> count=0, rempty=1, rvalid=0 next cycle.
REQ-043 Count=50, rst pulse during reads -> count=0, rvalid=0, flags cleared; next write/read returns new data.
